// File: rtl/arb_requester.sv
// Requester-side controller: queues one job per port, requests the arbiter,
// and on a legal one-hot grant drives the granted port's burst onto the shared bus.
module arb_requester #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       job_valid_i,
  input  logic [NUM_PORTS*CNT_W-1:0] job_len_i,
  output logic [NUM_PORTS-1:0]       job_ready_o,
  output logic [NUM_PORTS-1:0]       req_o,
  input  logic [NUM_PORTS-1:0]       gnt_i,
  output logic                       bus_valid_o,
  input  logic                       bus_ready_i,
  output logic [NUM_PORTS-1:0]       bus_owner_o,
  output logic [CNT_W-1:0]           bus_beat_o,
  output logic                       bus_last_o,
  output logic                       err_o
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NUM_PORTS-1:0]   r_pending;
  logic [CNT_W-1:0]       r_len [NUM_PORTS];
  logic [NUM_PORTS-1:0]   r_owner;
  logic [CNT_W-1:0]       r_beat;
  logic [CNT_W-1:0]       r_last_idx;
  logic                   r_err;

  logic                   w_gnt_any;
  logic                   w_gnt_legal;
  logic [NUM_PORTS-1:0]   w_take;
  logic [CNT_W-1:0]       w_sel_len;
  logic                   w_last;

  assign w_gnt_any   = |gnt_i;
  // Legal only in IDLE, where req_o mirrors pending.
  assign w_gnt_legal = (r_state == S_IDLE) && $onehot(gnt_i) && ((gnt_i & ~r_pending) == '0);
  assign w_take      = w_gnt_legal ? gnt_i : '0;
  assign w_last      = (r_beat == r_last_idx);

  always_comb begin
    w_sel_len = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_i[i]) w_sel_len = r_len[i];
    end
  end

  // Grant clear and job accept never collide: a grantable port has pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_len[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_take[i]) begin
          r_pending[i] <= 1'b0;
        end else if (job_valid_i[i] && !r_pending[i]) begin
          r_pending[i] <= 1'b1;
          r_len[i]     <= job_len_i[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_legal) w_state_next = S_BURST;
      S_BURST: if (bus_ready_i && w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= '0;
      r_beat     <= '0;
      r_last_idx <= '0;
    end else if (w_gnt_legal) begin
      r_owner    <= gnt_i;
      r_beat     <= '0;
      r_last_idx <= w_sel_len;
    end else if (r_state == S_BURST && bus_ready_i && !w_last) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_gnt_any && !w_gnt_legal) begin
      r_err <= 1'b1;
    end
  end

  assign job_ready_o = ~r_pending;
  assign req_o       = (r_state == S_IDLE)  ? r_pending : '0;
  assign bus_valid_o = (r_state == S_BURST);
  assign bus_owner_o = (r_state == S_BURST) ? r_owner : '0;
  assign bus_beat_o  = (r_state == S_BURST) ? r_beat  : '0;
  assign bus_last_o  = (r_state == S_BURST) && w_last;
  assign err_o       = r_err;

endmodule
